// File: rtl/pdp11_ea_unit_pkg.sv
// Shared types for the PDP-11 effective-address unit: addressing modes,
// operand size, memory access kinds, EA sequencer states and the
// autoincrement/autodecrement step rule.
package pdp11_ea_unit_pkg;

    typedef logic [15:0] word_t;
    typedef logic [2:0]  reg_t;

    typedef enum logic [2:0] {
        AM_REG         = 3'd0,
        AM_REG_DEF     = 3'd1,
        AM_AUTOINC     = 3'd2,
        AM_AUTOINC_DEF = 3'd3,
        AM_AUTODEC     = 3'd4,
        AM_AUTODEC_DEF = 3'd5,
        AM_INDEX       = 3'd6,
        AM_INDEX_DEF   = 3'd7
    } amod_t;

    typedef enum logic {
        WORD_OP = 1'b0,
        BYTE_OP = 1'b1
    } op_size;

    typedef enum logic [1:0] {
        DATA_READ  = 2'd0,
        DATA_WRITE = 2'd1,
        INST_FETCH = 2'd2
    } mem_access_t;

    typedef enum logic [1:0] {
        IDLE,
        IDX_FETCH,
        PTR_READ,
        FIN
    } ea_state_t;

    localparam reg_t  REG_SP    = 3'd6;
    localparam reg_t  REG_PC    = 3'd7;
    localparam word_t INST_STEP = 16'd2;

    // SP and PC must stay word aligned, and deferred modes step over a pointer
    // word, so only byte operands on R0-R5 in modes 2/4 step by one.
    function automatic word_t ea_step(input amod_t m, input reg_t r, input op_size s);
        if (s == WORD_OP || r == REG_SP || r == REG_PC ||
            m == AM_AUTOINC_DEF || m == AM_AUTODEC_DEF)
            return 16'd2;
        return 16'd1;
    endfunction

endpackage

// File: rtl/pdp11_ea_adder.sv
// Address arithmetic for the EA unit: register +/- step, PC past the index
// word, and index word + base. All sums wrap modulo 2^16.
module pdp11_ea_adder
    import pdp11_ea_unit_pkg::*;
(
    input  logic [15:0] base,
    input  logic [15:0] step,
    input  logic [15:0] pc,
    input  logic [15:0] idx,
    input  logic [15:0] idx_base,
    output logic [15:0] base_inc,
    output logic [15:0] base_dec,
    output logic [15:0] pc_next,
    output logic [15:0] idx_sum
);

    assign base_inc = base + step;
    assign base_dec = base - step;
    assign pc_next  = pc + INST_STEP;
    assign idx_sum  = idx + idx_base;

endmodule

// File: rtl/pdp11_ea_unit.sv
// PDP-11 operand effective-address generator. Takes the mode/register/size of
// one operand, performs the index-word fetch and deferred-pointer read where
// the mode needs them, issues the autoinc/autodec/PC write-back and returns
// the EA (or the register number for mode 0).
// Optional build macro MEM_TRACE_EN adds a simulation-only memory access log.
//
// state     | meaning
// IDLE      | waiting for start
// IDX_FETCH | index word read at pc_in (INST_FETCH)
// PTR_READ  | deferred pointer read (DATA_READ)
// FIN       | done pulse; a new start is accepted
module pdp11_ea_unit
   import pdp11_ea_unit_pkg::*;
#(
   parameter int STRICT_ALIGN = 1,
   parameter int MAX_WAIT     = 255
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  mode,
   input  logic [2:0]  rn,
   input  logic        sz,
   input  logic [15:0] reg_rdata,
   input  logic [15:0] pc_in,
   output logic        reg_wr_en,
   output logic [2:0]  reg_wr_addr,
   output logic [15:0] reg_wr_data,
   output logic        mem_req,
   output logic [15:0] mem_addr,
   output logic [1:0]  mem_type,
   input  logic        mem_ack,
   input  logic [15:0] mem_rdata,
   output logic        busy,
   output logic        done,
   output logic [15:0] ea,
   output logic        is_reg,
   output logic        err
);

   ea_state_t   state;
   amod_t       mode_in;
   amod_t       mode_q;
   word_t       base_q;
   word_t       pc_next_q;
   logic [15:0] wait_cnt;

   word_t       step;
   word_t       base_inc;
   word_t       base_dec;
   word_t       pc_next;
   word_t       idx_sum;
   word_t       ptr_addr;
   logic        wait_expired;

   assign mode_in      = amod_t'(mode);
   assign step         = ea_step(mode_in, rn, op_size'(sz));
   assign ptr_addr     = (mode_in == AM_AUTOINC_DEF) ? reg_rdata : base_dec;
   assign wait_expired = (wait_cnt + 16'd1) == 16'(MAX_WAIT);

   function automatic logic misaligned(input word_t a);
      return (STRICT_ALIGN != 0) && a[0];
   endfunction

   pdp11_ea_adder u_adder (
      .base     (reg_rdata),
      .step     (step),
      .pc       (pc_in),
      .idx      (mem_rdata),
      .idx_base (base_q),
      .base_inc (base_inc),
      .base_dec (base_dec),
      .pc_next  (pc_next),
      .idx_sum  (idx_sum)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         mode_q      <= AM_REG;
         base_q      <= '0;
         pc_next_q   <= '0;
         wait_cnt    <= '0;
         reg_wr_en   <= 1'b0;
         reg_wr_addr <= '0;
         reg_wr_data <= '0;
         mem_req     <= 1'b0;
         mem_addr    <= '0;
         mem_type    <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         ea          <= '0;
         is_reg      <= 1'b0;
         err         <= 1'b0;
      end else begin
         reg_wr_en <= 1'b0;
         done      <= 1'b0;
         case (state)
            IDLE, FIN: begin
               if (start) begin
                  busy     <= 1'b1;
                  mode_q   <= mode_in;
                  wait_cnt <= '0;
                  err      <= 1'b0;
                  is_reg   <= 1'b0;
                  case (mode_in)
                     AM_REG: begin
                        state  <= FIN;
                        done   <= 1'b1;
                        ea     <= {13'b0, rn};
                        is_reg <= 1'b1;
                     end
                     AM_REG_DEF: begin
                        state <= FIN;
                        done  <= 1'b1;
                        ea    <= reg_rdata;
                     end
                     AM_AUTOINC: begin
                        state       <= FIN;
                        done        <= 1'b1;
                        ea          <= reg_rdata;
                        reg_wr_en   <= 1'b1;
                        reg_wr_addr <= rn;
                        reg_wr_data <= base_inc;
                     end
                     AM_AUTODEC: begin
                        state       <= FIN;
                        done        <= 1'b1;
                        ea          <= base_dec;
                        reg_wr_en   <= 1'b1;
                        reg_wr_addr <= rn;
                        reg_wr_data <= base_dec;
                     end
                     AM_AUTOINC_DEF, AM_AUTODEC_DEF: begin
                        reg_wr_en   <= 1'b1;
                        reg_wr_addr <= rn;
                        reg_wr_data <= (mode_in == AM_AUTOINC_DEF) ? base_inc : base_dec;
                        if (misaligned(ptr_addr)) begin
                           state <= FIN;
                           done  <= 1'b1;
                           err   <= 1'b1;
                        end else begin
                           state    <= PTR_READ;
                           mem_req  <= 1'b1;
                           mem_addr <= ptr_addr;
                           mem_type <= DATA_READ;
                        end
                     end
                     AM_INDEX, AM_INDEX_DEF: begin
                        base_q    <= (rn == REG_PC) ? pc_next : reg_rdata;
                        pc_next_q <= pc_next;
                        if (misaligned(pc_in)) begin
                           state       <= FIN;
                           done        <= 1'b1;
                           err         <= 1'b1;
                           reg_wr_en   <= 1'b1;
                           reg_wr_addr <= REG_PC;
                           reg_wr_data <= pc_next;
                        end else begin
                           state    <= IDX_FETCH;
                           mem_req  <= 1'b1;
                           mem_addr <= pc_in;
                           mem_type <= INST_FETCH;
                        end
                     end
                     default: state <= IDLE;
                  endcase
               end else begin
                  state <= IDLE;
                  busy  <= 1'b0;
               end
            end
            IDX_FETCH: begin
               if (mem_ack) begin
                  mem_req     <= 1'b0;
                  wait_cnt    <= '0;
                  reg_wr_en   <= 1'b1;
                  reg_wr_addr <= REG_PC;
                  reg_wr_data <= pc_next_q;
                  if (mode_q == AM_INDEX) begin
                     state <= FIN;
                     done  <= 1'b1;
                     ea    <= idx_sum;
                  end else if (misaligned(idx_sum)) begin
                     state <= FIN;
                     done  <= 1'b1;
                     err   <= 1'b1;
                  end else begin
                     state    <= PTR_READ;
                     mem_req  <= 1'b1;
                     mem_addr <= idx_sum;
                     mem_type <= DATA_READ;
                  end
               end else if (wait_expired) begin
                  mem_req <= 1'b0;
                  state   <= FIN;
                  done    <= 1'b1;
                  err     <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            PTR_READ: begin
               if (mem_ack) begin
                  mem_req  <= 1'b0;
                  wait_cnt <= '0;
                  state    <= FIN;
                  done     <= 1'b1;
                  ea       <= mem_rdata;
               end else if (wait_expired) begin
                  mem_req <= 1'b0;
                  state   <= FIN;
                  done    <= 1'b1;
                  err     <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
            end
            default: begin
               state   <= IDLE;
               busy    <= 1'b0;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

`ifdef MEM_TRACE_EN
   logic debug;

   always @(posedge clk) begin
      if (mem_req && mem_ack)
         $display("%0d %o", mem_type, mem_addr);
      if (debug && done)
         $display("ea %o mode %0d", ea, mode_q);
   end
`endif

endmodule
